// File: rtl/add_sel_driver_pkg.sv
// Shared definitions for the two-sum select adder and its request-side driver.
// Both sides take the latency from here so they agree on pipeline depth.
package add_sel_driver_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    localparam int DEFAULT_LAT = 2;

endpackage

// File: rtl/add_sel_driver.sv
// Serial-to-parallel operand driver for the two-sum select adder.
// One transaction in flight: collect four words, wait out the adder latency, return the result.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready are
// both high. in_ready is high only in COLLECT. out_valid/out_data/out_err hold
// steady in RESP until out_ready is seen high on an edge.
module add_sel_driver
    import add_sel_driver_pkg::*;
#(
    parameter int size = 8,
    parameter int LAT  = DEFAULT_LAT
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_data,
    input  logic            in_sel,
    output logic [size-1:0] Datain1,
    output logic [size-1:0] Datain2,
    output logic [size-1:0] Datain3,
    output logic [size-1:0] Datain4,
    output logic            enable,
    input  logic [size-1:0] res_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_data,
    output logic            out_err,
    output logic            busy,
    output state_t          dbg_state
);

    localparam int CW = $clog2(LAT + 2);
    localparam logic [CW-1:0] LAT_C = CW'(LAT);

    state_t          state;
    logic [1:0]      idx;
    logic [CW-1:0]   cnt;
    logic [size-1:0] exp_sum;

    // Carry intentionally dropped so the reference wraps like the adder does.
    assign exp_sum   = enable ? (Datain1 + Datain2) : (Datain3 + Datain4);
    assign in_ready  = (state == ST_COLLECT);
    assign busy      = (state != ST_COLLECT);
    assign dbg_state = state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_COLLECT;
            idx       <= 2'd0;
            cnt       <= '0;
            Datain1   <= '0;
            Datain2   <= '0;
            Datain3   <= '0;
            Datain4   <= '0;
            enable    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_valid) begin
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: begin
                                Datain1 <= in_data;
                                enable  <= in_sel;
                            end
                            2'd1: Datain2 <= in_data;
                            2'd2: Datain3 <= in_data;
                            default: begin
                                Datain4 <= in_data;
                                cnt     <= '0;
                                state   <= ST_WAIT;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (cnt == LAT_C) begin
                        out_data  <= res_in;
                        out_err   <= (res_in != exp_sum);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule
